// File: rtl/register_file_2r1w.sv
// register_file_2r1w: MIPS 32x32 register file, two async read ports plus debug port, one sync write port; $0 reads zero, $sp resets to SP_INIT.
// Optional same-cycle write-through forwarding when REGFILE_WB_BYPASS_EN is defined.
module register_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DebugReg,
  output logic [DATA_W-1:0] DebugData
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [1:N-1];
  always_ff @(posedge Clk or posedge Reset)
    if (Reset)
      for (int i = 1; i < N; i++) regs[i] <= (i == 29) ? SP_INIT : '0;
    else if (RegWrite && WriteReg != '0)
      regs[WriteReg] <= WriteData;
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_WB_BYPASS_EN
    if (!Reset && RegWrite && WriteReg != '0 && a == WriteReg) return WriteData;
`endif
    return (a == '0) ? '0 : regs[a];
  endfunction
  assign ReadData1 = rd(ReadReg1);
  assign ReadData2 = rd(ReadReg2);
  assign DebugData = rd(DebugReg);
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: randomized + directed bench for register_file_2r1w against an array-based reference model.
module tb_register_file_2r1w;
  localparam logic [31:0] SP = 32'h0000_3FFC;
  logic clk = 0;
  logic Reset, RegWrite;
  logic [4:0] WriteReg, ReadReg1, ReadReg2, DebugReg;
  logic [31:0] WriteData, ReadData1, ReadData2, DebugData, rd1_0, rd2_0, dbg_0;
  logic [31:0] m [32];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  register_file_2r1w #(.SP_INIT(SP)) u_dut (
    .Clk(clk), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .DebugReg(DebugReg), .DebugData(DebugData));
  register_file_2r1w u_dut0 (
    .Clk(clk), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1_0), .ReadData2(rd2_0),
    .DebugReg(DebugReg), .DebugData(dbg_0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = (i == 29) ? SP : 32'h0;
  endtask
  function automatic logic [31:0] expv(input logic [4:0] a);
`ifdef REGFILE_WB_BYPASS_EN
    if (!Reset && RegWrite && WriteReg != 0 && a == WriteReg) return WriteData;
`endif
    return (a == 0) ? 32'h0 : m[a];
  endfunction
  task automatic check_all(input string tag);
    chk({tag, "_rd1"}, ReadData1, expv(ReadReg1));
    chk({tag, "_rd2"}, ReadData2, expv(ReadReg2));
    chk({tag, "_dbg"}, DebugData, expv(DebugReg));
  endtask
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr);
    @(negedge clk);
    RegWrite = we; WriteReg = wa; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2; DebugReg = dr;
    #1 check_all("pre");
    @(posedge clk);
    if (we && wa != 0) m[wa] = wd;
    #1 check_all("post");
  endtask
  initial begin
    Reset = 1; RegWrite = 0; WriteReg = 0; WriteData = 0;
    ReadReg1 = 0; ReadReg2 = 0; DebugReg = 0;
    model_reset();
    #2;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      #1;
      chk("rst_sweep", ReadData1, (i == 29) ? SP : 32'h0);
      chk("rst_sweep_sp0", rd1_0, 32'h0);
    end
    @(negedge clk) Reset = 0;
    cyc(1, 8, 32'hDEAD_BEEF, 0, 0, 8);
    cyc(0, 0, 0, 8, 8, 8);
    cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 5, 32'h1111_1111, 5, 5, 5);
    cyc(1, 5, 32'h2222_2222, 1, 5, 5);
    cyc(0, 0, 0, 5, 5, 5);
    for (int k = 0; k < 4; k++) cyc(0, 12, 32'hA5A5_A5A5, 12, 12, 12);
    for (int k = 0; k < 400; k++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      cyc(1'($urandom), wa, $urandom, ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
          5'($urandom), 5'($urandom));
    end
    cyc(1, 3, 32'd7, 3, 3, 3);
    @(negedge clk);
    RegWrite = 1; WriteReg = 3; WriteData = 32'd9; ReadReg1 = 3; ReadReg2 = 29; DebugReg = 3;
    #2 Reset = 1;
    model_reset();
    #1;
    chk("async_rst_r3", ReadData1, 32'h0);
    chk("async_rst_sp", ReadData2, SP);
    check_all("in_rst");
    @(posedge clk);
    #1 check_all("rst_edge");
    @(negedge clk);
    Reset = 0; RegWrite = 0;
    #1 check_all("rst_rel");
    for (int k = 0; k < 3; k++) cyc(0, 3, 32'd9, 3, 29, 3);
    chk("rst_r3_stays", ReadData1, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
